// File: rtl/vreduce_seq.sv
// Horizontal reduction sequencer: folds lanes of one vector into a scalar
// by driving the shared lane ALU in broadcast mode, one lane per cycle.
//
// Ports:
//   clk, rst (async, active-low)
//   start, op, len, vec        : request, operation, lane count, source vector
//   SrcAE, SrcBE, SrcBiE, ImmE,
//   ALUControlE, VSIFlagE      : operand/control drive to the lane ALU
//   ALUOutputE, ALUFlagsE      : lane ALU results (lane 0 used)
//   busy, done, result, flags  : status and reduction result
module vreduce_seq #(
  parameter int N     = 8,
  parameter int LANES = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [2:0]                op,
  input  logic [2:0]                len,
  input  logic [LANES-1:0][N-1:0]   vec,
  output logic [LANES-1:0][N-1:0]   SrcAE,
  output logic [LANES-1:0][N-1:0]   SrcBE,
  output logic [3:0]                SrcBiE,
  output logic [N-1:0]              ImmE,
  output logic [2:0]                ALUControlE,
  output logic [1:0]                VSIFlagE,
  input  logic [LANES-1:0][N-1:0]   ALUOutputE,
  input  logic [1:0]                ALUFlagsE,
  output logic                      busy,
  output logic                      done,
  output logic [N-1:0]              result,
  output logic [1:0]                flags
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                    r_state;
  logic [LANES-1:0][N-1:0]   r_vreg;
  logic [2:0]                r_op;
  logic [2:0]                r_len;
  logic [2:0]                r_idx;
  logic [N-1:0]              r_acc;
  logic [1:0]                r_flags;

  logic [2:0]                w_len_eff;
  logic                      w_run;
  logic                      w_unused;

  // Out-of-range lengths clamp to the nearest legal value.
  always_comb begin
    w_len_eff = len;
    if (len == 3'd0) w_len_eff = 3'd1;
    if (len == 3'd7) w_len_eff = 3'd6;
  end

  assign w_run    = (r_state == S_RUN);
  assign w_unused = ^ALUOutputE[LANES-1:1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_vreg  <= '0;
      r_op    <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_flags <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_vreg  <= vec;
            r_op    <= op;
            r_len   <= w_len_eff;
            r_acc   <= vec[0];
            r_idx   <= 3'd1;
            r_flags <= '0;
            r_state <= (w_len_eff >= 3'd2) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          r_acc   <= ALUOutputE[0];
          r_flags <= ALUFlagsE;
          if (r_idx == r_len - 3'd1) r_state <= S_DONE;
          else                       r_idx   <= r_idx + 3'd1;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign SrcAE       = w_run ? {LANES{r_acc}} : '0;
  assign SrcBE       = r_vreg;
  assign SrcBiE      = w_run ? {1'b0, r_idx} : 4'd0;
  assign ImmE        = '0;
  assign ALUControlE = w_run ? r_op : 3'd0;
  assign VSIFlagE    = w_run ? 2'b01 : 2'b00;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign result      = r_acc;
  assign flags       = r_flags;

endmodule

// File: tb/tb_vreduce_seq.sv
// Testbench for vreduce_seq with a behavioural lane ALU and a
// fold-order reference model.
module tb_vreduce_seq;
  localparam int N = 8;
  localparam int L = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [2:0]        op, len;
  logic [L-1:0][N-1:0] vec, SrcAE, SrcBE, ALUOutputE;
  logic [3:0]        SrcBiE;
  logic [N-1:0]      ImmE, result;
  logic [2:0]        ALUControlE;
  logic [1:0]        VSIFlagE, ALUFlagsE, flags;
  logic              busy, done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vreduce_seq #(.N(N), .LANES(L)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .len(len), .vec(vec),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .SrcBiE(SrcBiE), .ImmE(ImmE),
    .ALUControlE(ALUControlE), .VSIFlagE(VSIFlagE),
    .ALUOutputE(ALUOutputE), .ALUFlagsE(ALUFlagsE),
    .busy(busy), .done(done), .result(result), .flags(flags)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane ALU: returns {carry, zero, result}.
  function automatic logic [N+1:0] alu(input logic [N-1:0] a, b,
                                       input logic [2:0] o);
    logic [N:0] w;
    case (o)
      3'd0: w = {1'b0, a} + {1'b0, b};
      3'd1: w = {1'b0, a} - {1'b0, b};
      3'd2: w = {1'b0, a & b};
      3'd3: w = {1'b0, a | b};
      3'd4: w = {1'b0, a ^ b};
      3'd5: w = {1'b0, (a > b) ? a : b};
      3'd6: w = {1'b0, (a < b) ? a : b};
      default: w = {1'b0, a};
    endcase
    return {w[N], (w[N-1:0] == '0), w[N-1:0]};
  endfunction

  logic [N+1:0] lane_t [L];
  logic [N-1:0] bsel;
  always_comb begin
    bsel = SrcBE[0];
    if (SrcBiE < 4'd6) bsel = SrcBE[SrcBiE[2:0]];
    ALUFlagsE = 2'b00;
    for (int i = 0; i < L; i++) begin
      lane_t[i] = alu(SrcAE[i], (VSIFlagE == 2'b01) ? bsel : SrcBE[i],
                      ALUControlE);
      ALUOutputE[i] = lane_t[i][N-1:0];
    end
    ALUFlagsE = lane_t[0][N+1:N];
  end

  function automatic int leff_of(input logic [2:0] l);
    if (l == 3'd0) return 1;
    if (l == 3'd7) return 6;
    return int'(l);
  endfunction

  // Reference: sequential left fold over the first len_eff lanes.
  function automatic logic [N+1:0] ref_reduce(input logic [L-1:0][N-1:0] v,
                                              input logic [2:0] o,
                                              input logic [2:0] l);
    logic [N-1:0] a;
    logic [1:0]   f;
    logic [N+1:0] t;
    a = v[0];
    f = 2'b00;
    for (int i = 1; i < leff_of(l); i++) begin
      t = alu(a, v[i], o);
      a = t[N-1:0];
      f = t[N+1:N];
    end
    return {f, a};
  endfunction

  function automatic logic [L-1:0][N-1:0] rnd_vec();
    logic [L-1:0][N-1:0] v;
    for (int i = 0; i < L; i++) v[i] = N'($urandom);
    return v;
  endfunction

  task automatic run_red(input string tag, input logic [L-1:0][N-1:0] v,
                         input logic [2:0] o, input logic [2:0] l,
                         input bit perturb, output logic [N-1:0] res);
    int le, bc, rc;
    bit seen;
    logic [N+1:0] ex;
    logic [3:0] ei;
    le = leff_of(l);
    ex = ref_reduce(v, o, l);
    bc = 0; rc = 0; seen = 0; ei = 4'd1; res = '0;
    @(negedge clk);
    chk({tag, "/idle"}, busy, 0);
    start = 1'b1; vec = v; op = o; len = l;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 12 && !seen; cyc++) begin
      if (busy) bc++;
      if (VSIFlagE == 2'b01) begin
        rc++;
        chk({tag, "/srcbi"}, SrcBiE, ei);
        chk({tag, "/ctl"}, ALUControlE, o);
        ei++;
      end
      if (done) begin
        seen = 1;
        chk({tag, "/lat"}, cyc, le);
        chk({tag, "/res"}, result, ex[N-1:0]);
        chk({tag, "/flags"}, flags, ex[N+1:N]);
        res = result;
      end
      if (perturb) begin
        vec = rnd_vec();
        op = 3'($urandom);
        len = 3'($urandom);
        start = 1'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) chk({tag, "/timeout"}, 0, 1);
    chk({tag, "/busycyc"}, bc, le);
    chk({tag, "/runcyc"}, rc, le - 1);
    chk({tag, "/after_busy"}, busy, 0);
    chk({tag, "/after_done"}, done, 0);
  endtask

  logic [N-1:0] r, r0, r1, r6, r7;
  logic [L-1:0][N-1:0] v;
  logic [L-1:0][N-1:0] bl [2];
  logic [2:0] bln [2];
  logic [N-1:0] bex [2];
  int acc_cyc [2];
  int k, dn;
  bit sawdone;

  initial begin
    rst = 1'b0; start = 1'b0; vec = '0; op = 3'd0; len = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst/busy", busy, 0);
    chk("rst/done", done, 0);
    chk("rst/result", result, 0);
    chk("rst/flags", flags, 0);
    chk("rst/srca", SrcAE, 0);
    chk("rst/srcb", SrcBE, 0);
    chk("rst/srcbi", SrcBiE, 0);
    chk("rst/vsi", VSIFlagE, 0);
    chk("rst/ctl", ALUControlE, 0);
    chk("rst/imm", ImmE, 0);
    rst = 1'b1;

    v = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    run_red("sum", v, 3'd0, 3'd6, 1'b0, r);
    chk("sum/21", r, 21);

    v = {L{8'd100}};
    run_red("wrap", v, 3'd0, 3'd6, 1'b0, r);
    chk("wrap/88", r, 88);

    v = rnd_vec();
    run_red("len1", v, 3'd0, 3'd1, 1'b0, r1);
    chk("len1/v0", r1, v[0]);
    run_red("len0", v, 3'd0, 3'd0, 1'b0, r0);
    chk("len0/eq", r0, r1);
    run_red("len6", v, 3'd1, 3'd6, 1'b0, r6);
    run_red("len7", v, 3'd1, 3'd7, 1'b0, r7);
    chk("len7/eq", r7, r6);

    run_red("perturb", rnd_vec(), 3'd4, 3'd6, 1'b1, r);

    v = rnd_vec();
    @(negedge clk);
    start = 1'b1; vec = v; op = 3'd0; len = 3'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort/busy", busy, 0);
    chk("abort/done", done, 0);
    chk("abort/result", result, 0);
    chk("abort/flags", flags, 0);
    chk("abort/srca", SrcAE, 0);
    chk("abort/srcb", SrcBE, 0);
    chk("abort/srcbi", SrcBiE, 0);
    chk("abort/vsi", VSIFlagE, 0);
    chk("abort/ctl", ALUControlE, 0);
    sawdone = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) sawdone = 1;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) sawdone = 1;
    end
    chk("abort/nodone", sawdone, 0);
    v = rnd_vec();
    v[2:0] = {8'd3, 8'd2, 8'd1};
    run_red("post", v, 3'd0, 3'd3, 1'b0, r);
    chk("post/6", r, 6);

    bl[0] = rnd_vec(); bln[0] = 3'd4;
    bl[1] = rnd_vec(); bln[1] = 3'd5;
    for (int i = 0; i < 2; i++) begin
      logic [N+1:0] t;
      t = ref_reduce(bl[i], 3'd0, bln[i]);
      bex[i] = t[N-1:0];
    end
    k = 0; dn = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    @(negedge clk);
    start = 1'b1; op = 3'd0;
    for (int cyc = 0; cyc < 40 && dn < 2; cyc++) begin
      if (done) begin
        chk($sformatf("b2b/res%0d", dn), result, bex[dn]);
        dn++;
      end
      if (!busy && k < 2) begin
        vec = bl[k]; len = bln[k]; acc_cyc[k] = cyc; k++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b/dones", dn, 2);
    chk("b2b/gap", acc_cyc[1] - acc_cyc[0], leff_of(bln[0]) + 1);
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      run_red($sformatf("rnd%0d", i), rnd_vec(), 3'($urandom),
              3'($urandom), 1'($urandom), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
